// File: rtl/veda_pkg.sv
// Shared definitions for the veda dual-requester memory arbiter.
// Holds default widths, memory mode constants, FSM encoding and read latency.
package veda_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int RD_LAT     = 3;

   localparam logic MODE_SCRIBBLE  = 1'b0;
   localparam logic MODE_INTERPRET = 1'b1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } veda_state_e;

   typedef struct packed {
      logic valid;
      logic id;
   } veda_tag_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/veda_rr_pick.sv
// Two-way round-robin grant pick; the pointer names the requester that wins a tie
// and flips to the other requester whenever a grant is issued.
module veda_rr_pick
   import veda_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   logic prio_r;
   logic gnt0_s;
   logic gnt1_s;

   // Grant selection: a lone requester always wins, a tie goes to prio_r.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (enable) begin
         if (req0 && req1) begin
            gnt0_s = ~prio_r;
            gnt1_s = prio_r;
         end else begin
            gnt0_s = req0;
            gnt1_s = req1;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Priority pointer: grants are only issued to active requests, so a grant is an acceptance.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prio_r <= 1'b0;
      end else if (gnt0_s) begin
         prio_r <= 1'b1;
      end else if (gnt1_s) begin
         prio_r <= 1'b0;
      end else begin
         prio_r <= prio_r;
      end
   end

   assign gnt0 = gnt0_s;
   assign gnt1 = gnt1_s;

endmodule

// File: rtl/veda_arbiter.sv
// Dual-requester arbiter for a single-port memory with a 3-cycle read tag pipeline and flush FSM.
// Optional grant statistics are built when VEDA_ARBITER_STATS_EN is defined.
module veda_arbiter
   import veda_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_write_enable,
   output logic              mem_mode,
   output logic [ADDR_W-1:0] mem_address_a,
   output logic [ADDR_W-1:0] mem_address_b,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              busy,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1
);

   veda_state_e       state_r, state_s;
   logic              grant_en_s;
   logic              gnt0_s, gnt1_s;
   logic              acc0_s, acc1_s, acc_s;
   logic              acc_we_s;
   logic [ADDR_W-1:0] acc_addr_s;
   logic [DATA_W-1:0] acc_wdata_s;

   logic              cmd_we_r, cmd_we_s;
   logic              cmd_mode_r, cmd_mode_s;
   logic [ADDR_W-1:0] cmd_addr_a_r, cmd_addr_a_s;
   logic [ADDR_W-1:0] cmd_addr_b_r, cmd_addr_b_s;
   logic [DATA_W-1:0] cmd_data_r, cmd_data_s;

   veda_tag_t         tag1_r, tag2_r, tag3_r;
   logic              busy_s;

   // Grants are suppressed in reset, outside RUN, and in the very cycle a flush is requested.
   assign grant_en_s = reset && (state_r == ST_RUN) && !flush_req;

   veda_rr_pick u_pick (
      .clk    (clk),
      .reset  (reset),
      .enable (grant_en_s),
      .req0   (req0),
      .req1   (req1),
      .gnt0   (gnt0_s),
      .gnt1   (gnt1_s)
   );

   assign acc0_s      = req0 && gnt0_s;
   assign acc1_s      = req1 && gnt1_s;
   assign acc_s       = acc0_s || acc1_s;
   assign acc_we_s    = acc1_s ? we1    : we0;
   assign acc_addr_s  = acc1_s ? addr1  : addr0;
   assign acc_wdata_s = acc1_s ? wdata1 : wdata0;

   // Next memory command: write, read, or the idle command.
   always_comb begin
      cmd_we_s     = 1'b0;
      cmd_mode_s   = MODE_INTERPRET;
      cmd_addr_a_s = {ADDR_W{1'b0}};
      cmd_addr_b_s = {ADDR_W{1'b0}};
      cmd_data_s   = {DATA_W{1'b0}};
      if (acc_s && acc_we_s) begin
         cmd_we_s     = 1'b1;
         cmd_mode_s   = MODE_SCRIBBLE;
         cmd_addr_a_s = acc_addr_s;
         cmd_data_s   = acc_wdata_s;
      end else if (acc_s) begin
         cmd_addr_b_s = acc_addr_s;
      end else begin
         cmd_we_s     = 1'b0;
      end
   end

   // Command register and read tag pipeline.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cmd_we_r     <= 1'b0;
         cmd_mode_r   <= MODE_INTERPRET;
         cmd_addr_a_r <= {ADDR_W{1'b0}};
         cmd_addr_b_r <= {ADDR_W{1'b0}};
         cmd_data_r   <= {DATA_W{1'b0}};
         tag1_r       <= '{valid: 1'b0, id: 1'b0};
         tag2_r       <= '{valid: 1'b0, id: 1'b0};
         tag3_r       <= '{valid: 1'b0, id: 1'b0};
      end else begin
         cmd_we_r     <= cmd_we_s;
         cmd_mode_r   <= cmd_mode_s;
         cmd_addr_a_r <= cmd_addr_a_s;
         cmd_addr_b_r <= cmd_addr_b_s;
         cmd_data_r   <= cmd_data_s;
         tag1_r       <= '{valid: acc_s && !acc_we_s, id: acc1_s};
         tag2_r       <= tag1_r;
         tag3_r       <= tag2_r;
      end
   end

   // tag1 mirrors a read sitting in the command register.
   assign busy_s = tag1_r.valid || tag2_r.valid || tag3_r.valid;

   // Flush FSM next state.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (flush_req) state_s = ST_FLUSH;
            else           state_s = ST_RUN;
         end
         ST_FLUSH: begin
            if (!busy_s && !cmd_we_r) state_s = ST_DONE;
            else                      state_s = ST_FLUSH;
         end
         ST_DONE: begin
            if (!flush_req) state_s = ST_RUN;
            else            state_s = ST_DONE;
         end
         default: state_s = ST_RUN;
      endcase
   end

   // Flush FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) state_r <= ST_RUN;
      else        state_r <= state_s;
   end

   assign gnt0             = gnt0_s;
   assign gnt1             = gnt1_s;
   assign rvalid0          = tag3_r.valid && !tag3_r.id;
   assign rvalid1          = tag3_r.valid &&  tag3_r.id;
   assign rdata0           = rvalid0 ? mem_data_out : {DATA_W{1'b0}};
   assign rdata1           = rvalid1 ? mem_data_out : {DATA_W{1'b0}};
   assign mem_write_enable = cmd_we_r;
   assign mem_mode         = cmd_mode_r;
   assign mem_address_a    = cmd_addr_a_r;
   assign mem_address_b    = cmd_addr_b_r;
   assign mem_data_in      = cmd_data_r;
   assign busy             = busy_s;
   assign flush_done       = (state_r == ST_DONE);

`ifdef VEDA_ARBITER_STATS_EN
   logic [15:0] cnt0_r, cnt1_r;

   // Saturating acceptance counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt0_r <= 16'h0000;
         cnt1_r <= 16'h0000;
      end else begin
         cnt0_r <= acc0_s ? sat_inc16(cnt0_r) : cnt0_r;
         cnt1_r <= acc1_s ? sat_inc16(cnt1_r) : cnt1_r;
      end
   end

   assign gnt_cnt0 = cnt0_r;
   assign gnt_cnt1 = cnt1_r;
`else
   assign gnt_cnt0 = 16'h0000;
   assign gnt_cnt1 = 16'h0000;
`endif

endmodule
